// File: rtl/nikor_clock_pkg.sv
// Shared types and constants for the nikor mm:ss seven-segment clock.
package nikor_clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam bcd_t ONES_MAX     = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_TENS_MAX = 4'd5;

    localparam logic [1:0] SEL_SEC_ONES = 2'b00;
    localparam logic [1:0] SEL_SEC_TENS = 2'b01;
    localparam logic [1:0] SEL_MIN_ONES = 2'b10;
    localparam logic [1:0] SEL_MIN_TENS = 2'b11;

endpackage

// File: rtl/nikor_clock_seg7.sv
// Combinational BCD to seven-segment decoder (bit0 = a ... bit6 = g, active-high).
module nikor_clock_seg7
    import nikor_clock_pkg::*;
(
    input  bcd_t       digit_i,
    output logic [6:0] seg_o
);

    // Non-decimal codes blank the display.
    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/nikor_clock_core.sv
// mm:ss clock: prescaler, BCD cascade and digit mux feeding one seven-segment display.
// Optional decimal-point blink on every second: define NIKOR_CLOCK_DP_BLINK_EN.
module nikor_clock_core
    import nikor_clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int PRESCALE_W    = 16
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(TICKS_PER_SEC - 1);

    logic                  clk_s;
    logic                  rst_s;
    logic [1:0]            sel_s;
    logic                  unused_s;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  tick_s;
    bcd_t                  sec_ones_q, sec_ones_d;
    bcd_t                  sec_tens_q, sec_tens_d;
    bcd_t                  min_ones_q, min_ones_d;
    bcd_t                  min_tens_q, min_tens_d;
    bcd_t                  digit_s;
    logic [6:0]            seg_s;
    logic                  dp_s;

    assign clk_s    = io_in[0];
    assign rst_s    = io_in[1];
    assign sel_s    = io_in[3:2];
    assign unused_s = ^io_in[7:4];

    always_comb begin
        prescale_d = prescale_q + PRESCALE_W'(1);
        tick_s     = 1'b0;
        if (prescale_q == PRESCALE_LAST) begin
            prescale_d = '0;
            tick_s     = 1'b1;
        end else begin
            tick_s     = 1'b0;
        end
    end

    // Whole carry chain resolves in one edge so 59:59 goes straight to 00:00.
    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        if (tick_s) begin
            if (sec_ones_q == ONES_MAX) begin
                sec_ones_d = 4'd0;
                if (sec_tens_q == SEC_TENS_MAX) begin
                    sec_tens_d = 4'd0;
                    if (min_ones_q == ONES_MAX) begin
                        min_ones_d = 4'd0;
                        if (min_tens_q == MIN_TENS_MAX) begin
                            min_tens_d = 4'd0;
                        end else begin
                            min_tens_d = min_tens_q + 4'd1;
                        end
                    end else begin
                        min_ones_d = min_ones_q + 4'd1;
                    end
                end else begin
                    sec_tens_d = sec_tens_q + 4'd1;
                end
            end else begin
                sec_ones_d = sec_ones_q + 4'd1;
            end
        end else begin
            sec_ones_d = sec_ones_q;
        end
    end

    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            prescale_q <= '0;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
        end else begin
            prescale_q <= prescale_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
        end
    end

`ifdef NIKOR_CLOCK_DP_BLINK_EN
    logic dp_q, dp_d;

    assign dp_d = tick_s ? ~dp_q : dp_q;

    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            dp_q <= 1'b0;
        end else begin
            dp_q <= dp_d;
        end
    end

    assign dp_s = dp_q;
`else
    assign dp_s = 1'b0;
`endif

    always_comb begin
        digit_s = sec_ones_q;
        case (sel_s)
            SEL_SEC_ONES: digit_s = sec_ones_q;
            SEL_SEC_TENS: digit_s = sec_tens_q;
            SEL_MIN_ONES: digit_s = min_ones_q;
            SEL_MIN_TENS: digit_s = min_tens_q;
            default:      digit_s = sec_ones_q;
        endcase
    end

    nikor_clock_seg7 u_seg7 (
        .digit_i (digit_s),
        .seg_o   (seg_s)
    );

    assign io_out = {dp_s, seg_s};

endmodule

// File: tb/tb_nikor_clock_core.sv
// Self-checking bench for nikor_clock_core with TICKS_PER_SEC=10; the reference
// model derives every digit from the count of rising edges since reset release.
module tb_nikor_clock_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sel = 2'b00;
    logic [3:0] res_bits = 4'b0000;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int edges    = 0;
    int n_checks = 0;
    int n_fails  = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    assign io_in = {res_bits, sel, rst, clk};

    nikor_clock_core #(
        .TICKS_PER_SEC (10),
        .PRESCALE_W    (16)
    ) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input int e, input logic [1:0] s);
        int t;
        int d;
        t = (e / 10) % 3600;
        case (s)
            2'd0:    d = t % 10;
            2'd1:    d = (t / 10) % 6;
            2'd2:    d = (t / 60) % 10;
            default: d = t / 600;
        endcase
        return seg_tab[d];
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst) edges = 0;
            else     edges++;
        end
        #1;
    endtask

    task automatic chk(input string tag);
        logic [6:0] es;
        logic       ed;
        es = exp_seg(edges, sel);
`ifdef NIKOR_CLOCK_DP_BLINK_EN
        ed = ((edges / 10) % 2) == 1;
`else
        ed = 1'b0;
`endif
        n_checks++;
        assert (io_out[6:0] === es) else begin
            n_fails++;
            $error("FAIL %s seg sel=%0d edges=%0d got=%h exp=%h", tag, sel, edges, io_out[6:0], es);
        end
        n_checks++;
        assert (io_out[7] === ed) else begin
            n_fails++;
            $error("FAIL %s dp edges=%0d got=%b exp=%b", tag, edges, io_out[7], ed);
        end
    endtask

    task automatic chk_all(input string tag);
        logic [1:0] saved;
        saved = sel;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk(tag);
        end
        sel = saved;
        #1;
    endtask

    initial begin
        // Reset held for three edges.
        rst = 1'b1;
        sel = 2'b00;
        step(3);
        chk_all("reset");

        // Release and watch every edge through the ones wrap at 10 s.
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            chk("free_run");
        end
        chk_all("ten_sec");

        // Up to 59 s, then the minute carry.
        step(590 - edges);
        chk_all("59s");
        step(10);
        chk_all("60s");

        // 59:59 and the full wrap back to 00:00.
        step(35990 - edges);
        chk_all("59m59s");
        step(9);
        chk_all("wrap_minus1");
        step(1);
        chk_all("wrap");

        // Reset mid-count at prescaler 7 after 4 ticks.
        step(47 - (edges % 36000));
        chk_all("pre_reset");
        rst = 1'b1;
        step(1);
        chk_all("mid_reset");
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("post_reset");
        end

        // Randomised runs, selects, reserved bits and occasional resets.
        for (int i = 0; i < 60; i++) begin
            res_bits = 4'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                step($urandom_range(1, 3));
                rst = 1'b0;
            end
            step($urandom_range(1, 40));
            sel = 2'($urandom);
            #1;
            chk("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
